// File: rtl/tcb_fc_layer_if.sv
// tcb_fc_layer_if: vector, start/done and weight ROM signals of one fully-connected layer
interface tcb_fc_layer_if #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 10,
  parameter int LANES = 2,
  parameter int IN_W  = 19,
  parameter int W_W   = 8,
  parameter int ACC_W = 28,
  parameter int AW    = $clog2((N_OUT/LANES)*(N_IN+1))
);
  logic [N_IN*IN_W-1:0]   layer_in;
  logic                   valid;
  logic [AW-1:0]          w_addr;
  logic                   w_en;
  logic [LANES*W_W-1:0]   w_rdata;
  logic [N_OUT*ACC_W-1:0] layer_out;
  logic                   ready;
  logic                   busy;
  modport master (output layer_in, valid, w_rdata, input w_addr, w_en, layer_out, ready, busy);
  modport slave  (input layer_in, valid, w_rdata, output w_addr, w_en, layer_out, ready, busy);
endinterface

// File: rtl/tcb_fc_layer.sv
// tcb_fc_layer: time-multiplexed fully-connected layer, LANES MACs fed from a synchronous weight ROM
module tcb_fc_layer #(
  parameter int N_IN      = 16,
  parameter int N_OUT     = 10,
  parameter int LANES     = 2,
  parameter int IN_W      = 19,
  parameter bit IN_SIGNED = 0,
  parameter int W_W       = 8,
  parameter int ACC_W     = 28,
  parameter bit RELU      = 1,
  parameter int AW        = $clog2((N_OUT/LANES)*(N_IN+1))
) (
  input logic clk,
  input logic rst,
  tcb_fc_layer_if.slave bus
);
  localparam int G  = N_OUT/LANES;
  localparam int IW = $clog2(N_IN+1);
  localparam int GW = (G > 1) ? $clog2(G) : 1;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] LAST  = 3'd2;
  localparam logic [2:0] STORE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  logic [2:0]             state_q, state_d;
  logic [IW-1:0]          i_q, i_d;
  logic [GW-1:0]          g_q, g_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [N_IN*IN_W-1:0]   in_q, in_d;
  logic [N_OUT*ACC_W-1:0] out_q, out_d;
  logic [ACC_W-1:0]       acc_q [LANES];
  logic [ACC_W-1:0]       acc_d [LANES];
  logic [IW-1:0]          sel;
  logic [IN_W-1:0]        x;
  logic [ACC_W-1:0]       op;
  logic                   acc_en, acc_clr;
  assign bus.w_en      = state_q == RUN;
  assign bus.w_addr    = bus.w_en ? addr_q : '0;
  assign bus.layer_out = out_q;
  assign bus.ready     = state_q == DONE;
  assign bus.busy      = state_q != IDLE;
  always_comb begin
    // ROM data lags the address by one cycle, so RUN with i>0 consumes input i-1 and LAST the bias row
    sel     = (i_q == '0) ? '0 : i_q - 1'b1;
    x       = in_q[sel*IN_W +: IN_W];
    op      = (state_q == LAST) ? ACC_W'(1) : {{(ACC_W-IN_W){IN_SIGNED && x[IN_W-1]}}, x};
    acc_en  = (state_q == RUN && i_q != '0) || state_q == LAST;
    acc_clr = !(state_q == RUN || state_q == LAST);
    for (int l = 0; l < LANES; l++)
      acc_d[l] = acc_clr ? '0 :
                 acc_en  ? acc_q[l] + op * {{(ACC_W-W_W){bus.w_rdata[l*W_W+W_W-1]}}, bus.w_rdata[l*W_W +: W_W]} :
                           acc_q[l];
    out_d = out_q;
    for (int j = 0; j < N_OUT; j++)
      if (state_q == STORE && 32'(g_q) == j/LANES)
        out_d[j*ACC_W +: ACC_W] = (RELU && acc_q[j%LANES][ACC_W-1]) ? '0 : acc_q[j%LANES];
    state_d = state_q;
    i_d     = i_q;
    g_d     = g_q;
    addr_d  = addr_q;
    in_d    = in_q;
    case (state_q)
      IDLE: if (bus.valid) begin
        in_d    = bus.layer_in;
        i_d     = '0;
        g_d     = '0;
        addr_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        addr_d  = addr_q + 1'b1;
        i_d     = (i_q == IW'(N_IN)) ? i_q : i_q + 1'b1;
        state_d = (i_q == IW'(N_IN)) ? LAST : RUN;
      end
      LAST: state_d = STORE;
      STORE: begin
        i_d     = '0;
        g_d     = (g_q == GW'(G-1)) ? g_q : g_q + 1'b1;
        state_d = (g_q == GW'(G-1)) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      g_q     <= '0;
      addr_q  <= '0;
      in_q    <= '0;
      out_q   <= '0;
      acc_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      g_q     <= g_d;
      addr_q  <= addr_d;
      in_q    <= in_d;
      out_q   <= out_d;
      acc_q   <= acc_d;
    end
  end
endmodule

// File: tb/tb_tcb_fc_layer.sv
// tb_tcb_fc_layer: scoreboard bench for an unsigned/ReLU and a signed/linear tcb_fc_layer on one shared ROM
module tb_tcb_fc_layer;
  localparam int N_IN = 16, N_OUT = 10, LANES = 2, IN_W = 19, W_W = 8, ACC_W = 28;
  localparam int G = N_OUT/LANES, ROWS = G*(N_IN+1), AW = $clog2(ROWS), LAT = 1 + G*(N_IN+3);
  localparam int VW = N_IN*IN_W, OW = N_OUT*ACC_W;
  logic clk = 0, rst = 1;
  int cyc = 0, checks = 0, failures = 0, rdy_a = 0, rdy_b = 0, t0 = 0;
  logic [LANES*W_W-1:0] rom [ROWS];
  logic [OW-1:0] q_a[$], q_b[$];
  tcb_fc_layer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .LANES(LANES), .IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W), .AW(AW)) ifa ();
  tcb_fc_layer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .LANES(LANES), .IN_W(IN_W), .W_W(W_W), .ACC_W(ACC_W), .AW(AW)) ifb ();
  tcb_fc_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .LANES(LANES), .IN_W(IN_W), .IN_SIGNED(0), .W_W(W_W), .ACC_W(ACC_W), .RELU(1), .AW(AW))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  tcb_fc_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .LANES(LANES), .IN_W(IN_W), .IN_SIGNED(1), .W_W(W_W), .ACC_W(ACC_W), .RELU(0), .AW(AW))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));
  assign ifb.layer_in = ifa.layer_in;
  assign ifb.valid    = ifa.valid;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ifa.w_en) ifa.w_rdata <= rom[ifa.w_addr];
  always @(posedge clk) if (ifb.w_en) ifb.w_rdata <= rom[ifb.w_addr];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [OW-1:0] model(input logic [VW-1:0] v, input bit sgn, input bit relu);
    logic [OW-1:0] r;
    logic signed [W_W-1:0] w;
    logic [ACC_W-1:0] t;
    longint acc, xv;
    int base;
    r = '0;
    for (int j = 0; j < N_OUT; j++) begin
      base = (j/LANES)*(N_IN+1);
      w = rom[base+N_IN][(j%LANES)*W_W +: W_W];
      acc = longint'(w);
      for (int i = 0; i < N_IN; i++) begin
        w = rom[base+i][(j%LANES)*W_W +: W_W];
        xv = sgn ? longint'($signed(v[i*IN_W +: IN_W])) : longint'(v[i*IN_W +: IN_W]);
        acc += xv * longint'(w);
      end
      t = acc[ACC_W-1:0];
      if (relu && t[ACC_W-1]) t = '0;
      r[j*ACC_W +: ACC_W] = t;
    end
    return r;
  endfunction
  always @(negedge clk) if (!rst) begin
    if (ifa.ready) begin
      logic [OW-1:0] e;
      rdy_a++;
      if (q_a.size() == 0) check("a_sb_empty", 64'(q_a.size()), 1);
      else begin
        e = q_a.pop_front();
        for (int j = 0; j < N_OUT; j++) check("a_out", 64'(ifa.layer_out[j*ACC_W +: ACC_W]), 64'(e[j*ACC_W +: ACC_W]));
      end
    end
    if (ifb.ready) begin
      logic [OW-1:0] e;
      rdy_b++;
      if (q_b.size() == 0) check("b_sb_empty", 64'(q_b.size()), 1);
      else begin
        e = q_b.pop_front();
        for (int j = 0; j < N_OUT; j++) check("b_out", 64'(ifb.layer_out[j*ACC_W +: ACC_W]), 64'(e[j*ACC_W +: ACC_W]));
      end
    end
  end
  task automatic set_rom(input int w, input int b);
    for (int r = 0; r < ROWS; r++) rom[r] = {LANES{(r % (N_IN+1) == N_IN) ? W_W'(b) : W_W'(w)}};
  endtask
  task automatic rand_rom();
    for (int r = 0; r < ROWS; r++) rom[r] = (LANES*W_W)'($urandom);
  endtask
  function automatic logic [VW-1:0] fill(input int x);
    return {N_IN{IN_W'(x)}};
  endfunction
  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < N_IN; i++) v[i*IN_W +: IN_W] = IN_W'($urandom);
    return v;
  endfunction
  task automatic start(input logic [VW-1:0] v);
    @(negedge clk);
    ifa.layer_in = v;
    ifa.valid = 1;
    q_a.push_back(model(v, 0, 1));
    q_b.push_back(model(v, 1, 0));
    t0 = cyc;
  endtask
  task automatic wait_ready(input bit hold_valid);
    bit busy_ok = 1;
    int n = 0;
    @(negedge clk);
    if (!hold_valid) ifa.valid = 0;
    while (!ifa.ready && n < 300) begin
      busy_ok &= ifa.busy & ifb.busy;
      @(negedge clk);
      n++;
    end
    check("ready_seen", 64'(ifa.ready), 1);
    check("b_ready_same_cycle", 64'(ifb.ready), 1);
    check("latency", 64'(cyc - t0), 64'(LAT));
    check("busy_during_run", 64'(busy_ok & ifa.busy), 1);
    @(negedge clk);
    ifa.valid = 0;
    check("ready_width", 64'(ifa.ready), 0);
    check("busy_after_done", 64'(ifa.busy), 0);
  endtask
  task automatic run_vec(input logic [VW-1:0] v);
    start(v);
    wait_ready(0);
  endtask
  initial begin
    int r0;
    logic [VW-1:0] v;
    ifa.valid = 0;
    ifa.layer_in = '0;
    set_rom(0, 0);
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ifa.ready), 0);
    check("rst_busy", 64'(ifa.busy), 0);
    check("rst_w_en", 64'(ifa.w_en), 0);
    check("rst_w_addr", 64'(ifa.w_addr), 0);
    check("rst_layer_out", 64'(ifa.layer_out == '0), 1);
    rst = 0;
    set_rom(1, 0);
    run_vec(fill(1));
    check("ones_n0", 64'(ifa.layer_out[0 +: ACC_W]), 16);
    check("ones_n9", 64'(ifa.layer_out[9*ACC_W +: ACC_W]), 16);
    set_rom(1, 7);
    run_vec(fill(0));
    check("bias_only_n4", 64'(ifa.layer_out[4*ACC_W +: ACC_W]), 7);
    set_rom(-1, 0);
    run_vec(fill(2));
    check("neg_relu_n3", 64'(ifa.layer_out[3*ACC_W +: ACC_W]), 0);
    check("neg_linear_n3", 64'(ifb.layer_out[3*ACC_W +: ACC_W]), 64'(28'hFFFFFE0));
    set_rom(3, 5);
    run_vec(fill(-1));
    check("signed_n8", 64'(ifb.layer_out[8*ACC_W +: ACC_W]), 64'(28'hFFFFFD5));
    check("unsigned_n8", 64'(ifa.layer_out[8*ACC_W +: ACC_W]), 64'(524287*48 + 5));
    rand_rom();
    repeat (3) run_vec(rand_vec());
    // a second start and a new input mid-run, with valid held through DONE, must not be taken
    r0 = rdy_a;
    v = rand_vec();
    start(v);
    @(negedge clk);
    ifa.valid = 0;
    repeat (8) @(negedge clk);
    ifa.layer_in = ~v;
    ifa.valid = 1;
    wait_ready(1);
    repeat (120) @(negedge clk);
    check("single_ready_after_ignore", 64'(rdy_a - r0), 1);
    check("idle_after_ignore", 64'(ifa.busy), 0);
    // abort a run with reset, then a fresh vector must complete normally
    r0 = rdy_a;
    start(rand_vec());
    @(negedge clk);
    ifa.valid = 0;
    repeat (39) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    void'(q_a.pop_back());
    void'(q_b.pop_back());
    check("abort_layer_out", 64'(ifa.layer_out == '0), 1);
    check("abort_busy", 64'(ifa.busy), 0);
    check("abort_w_en", 64'(ifa.w_en), 0);
    check("abort_w_addr", 64'(ifa.w_addr), 0);
    run_vec(rand_vec());
    check("ready_count_after_abort", 64'(rdy_a - r0), 1);
    check("b_ready_count", 64'(rdy_b), 64'(rdy_a));
    check("sb_drained", 64'(q_a.size() + q_b.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
